// File: rtl/div_pkg.sv
// Shared constants and types for the multi-cycle integer divider.
package div_pkg;

  localparam int unsigned DIV_DATA_W = 32;
  localparam int unsigned DIV_CNT_W  = 6;

  // Divider state codes (2-bit, matching the legacy encoding).
  localparam logic [1:0] DIV_FREE    = 2'b00;
  localparam logic [1:0] DIV_BY_ZERO = 2'b01;
  localparam logic [1:0] DIV_ON      = 2'b10;
  localparam logic [1:0] DIV_END     = 2'b11;

  // Reset level for this block: active-low.
  localparam logic RST_ENABLE = 1'b0;

  // Sign fixups captured with the operands.
  typedef struct packed {
    logic neg_quo;
    logic neg_rem;
  } div_sign_t;

endpackage

// File: rtl/div.sv
// Radix-2 restoring divider: one quotient bit per clock, result is {remainder, quotient}.
module div
  import div_pkg::*;
#(
  parameter int unsigned DATA_W = DIV_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int unsigned RES_W = 2 * DATA_W;

  logic [1:0]           state_q, state_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]    rem_q, rem_d;
  logic [DATA_W-1:0]    quo_q, quo_d;
  logic [DATA_W-1:0]    dvs_q, dvs_d;
  div_sign_t            sign_q, sign_d;
  logic [RES_W-1:0]     result_q, result_d;
  logic                 ready_q, ready_d;

  logic                 op1_neg, op2_neg;
  logic [DATA_W-1:0]    mag1, mag2;
  logic [DATA_W:0]      shifted;
  logic [DATA_W+1:0]    trial;
  logic [DATA_W-1:0]    quo_fix, rem_fix;

  // Operand magnitudes; only meaningful negatives when dividing signed.
  assign op1_neg = signed_div_i & opdata1_i[DATA_W-1];
  assign op2_neg = signed_div_i & opdata2_i[DATA_W-1];
  assign mag1    = op1_neg ? -opdata1_i : opdata1_i;
  assign mag2    = op2_neg ? -opdata2_i : opdata2_i;

  // Partial remainder shifted left, pulling in the next dividend bit.
  assign shifted = {rem_q, quo_q[DATA_W-1]};

  // Trial subtract; the top bit is the borrow (1 = divisor did not fit).
  assign trial   = {1'b0, shifted} - {2'b00, dvs_q};

  // Final sign corrections applied once all quotient bits are in.
  assign quo_fix = sign_q.neg_quo ? -quo_q : quo_q;
  assign rem_fix = sign_q.neg_rem ? -rem_q : rem_q;

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    sign_d   = sign_q;
    result_d = result_q;
    ready_d  = ready_q;

    case (state_q)
      DIV_FREE: begin
        result_d = '0;
        ready_d  = 1'b0;
        if (start_i && !annul_i) begin
          rem_d          = '0;
          quo_d          = mag1;
          dvs_d          = mag2;
          sign_d.neg_quo = op1_neg ^ op2_neg;
          sign_d.neg_rem = op1_neg;
          cnt_d          = '0;
          state_d        = (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
        end
      end

      DIV_BY_ZERO: begin
        result_d = '0;
        ready_d  = 1'b1;
        state_d  = DIV_END;
      end

      DIV_ON: begin
        if (annul_i) begin
          state_d  = DIV_FREE;
          cnt_d    = '0;
          result_d = '0;
          ready_d  = 1'b0;
        end else if (cnt_q < DIV_CNT_W'(DATA_W)) begin
          // Keep the difference when it fits, otherwise restore.
          rem_d = trial[DATA_W+1] ? DATA_W'(shifted) : DATA_W'(trial);
          quo_d = {quo_q[DATA_W-2:0], ~trial[DATA_W+1]};
          cnt_d = cnt_q + DIV_CNT_W'(1);
        end else begin
          result_d = {rem_fix, quo_fix};
          ready_d  = 1'b1;
          state_d  = DIV_END;
        end
      end

      DIV_END: begin
        // Result is held until ex drops its request; annul has no effect here.
        if (!start_i) begin
          state_d  = DIV_FREE;
          result_d = '0;
          ready_d  = 1'b0;
        end
      end

      default: begin
        state_d  = DIV_FREE;
        cnt_d    = '0;
        result_d = '0;
        ready_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q  <= DIV_FREE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      sign_q   <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      sign_q   <= sign_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: randomized and directed operations against an arithmetic model.
module tb_div;

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1, op2;
  logic        start, annul;
  logic [63:0] result;
  logic        ready;

  // Expected outputs after the next rising edge, set by the driver.
  logic        exp_ready;
  logic [63:0] exp_result;
  string       tag;

  int n_checks;
  int n_pass;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {remainder, quotient} from plain integer arithmetic, truncating toward zero.
  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  // Compare DUT outputs just after every rising edge.
  always @(posedge clk) begin
    #1;
    n_checks++;
    if (ready === exp_ready && result === exp_result) n_pass++;
    else $display("FAIL %s t=%0t ready got %0b want %0b, result got %h want %h",
                  tag, $time, ready, exp_ready, result, exp_result);
  end

  task automatic pin(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL pin_%s got %h want %h", name, got, want);
  endtask

  // Advance one edge expecting the given outputs after it.
  task automatic cyc(input logic er, input logic [63:0] eres);
    exp_ready  = er;
    exp_result = eres;
    @(negedge clk);
  endtask

  // Full operation. pulse>0 drops start after that many edges past E0; hold = extra result cycles.
  task automatic op(input string name, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                    input int hold, input int pulse);
    logic [63:0] e;
    int lat;
    e   = model(sgn, a, b);
    lat = (b == 32'd0) ? 1 : 33;
    tag = name;
    signed_div = sgn; op1 = a; op2 = b; start = 1'b1; annul = 1'b0;
    cyc(1'b0, 64'd0);                      // E0: operands sampled
    op1 = $urandom; op2 = $urandom; signed_div = 1'($urandom);
    for (int i = 1; i < lat; i++) begin
      if (pulse != 0 && i >= pulse) start = 1'b0;
      cyc(1'b0, 64'd0);
    end
    cyc(1'b1, e);                          // result edge
    if (start) begin
      for (int h = 0; h < hold; h++) begin
        annul = (h == 0);                  // ignored while holding the result
        cyc(1'b1, e);
      end
    end
    annul = 1'b0;
    start = 1'b0;
    cyc(1'b0, 64'd0);
  endtask

  // Start an operation then annul it at iteration k (1..33); no result may appear.
  task automatic op_annul(input logic [31:0] a, input logic [31:0] b, input int k);
    tag = "annul";
    signed_div = 1'b0; op1 = a; op2 = b; start = 1'b1; annul = 1'b0;
    cyc(1'b0, 64'd0);
    for (int i = 1; i < k; i++) cyc(1'b0, 64'd0);
    annul = 1'b1;
    cyc(1'b0, 64'd0);
    annul = 1'b0;
  endtask

  // Start an operation then reset at iteration k; start stays high afterwards.
  task automatic op_reset(input logic [31:0] a, input logic [31:0] b, input int k);
    tag = "reset_mid";
    signed_div = 1'b0; op1 = a; op2 = b; start = 1'b1; annul = 1'b0;
    cyc(1'b0, 64'd0);
    for (int i = 1; i < k; i++) cyc(1'b0, 64'd0);
    rst = 1'b0;
    cyc(1'b0, 64'd0);
    rst = 1'b1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 7)
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return $urandom >> ($urandom % 32);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    n_checks = 0; n_pass = 0;
    rst = 1'b0; start = 1'b0; annul = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0;
    tag = "reset";
    exp_ready = 1'b0; exp_result = 64'd0;

    // Hand-computed values pinning the model.
    pin("u100_7",    model(1'b0, 32'd100, 32'd7),               64'h00000002_0000000E);
    pin("s-7_2",     model(1'b1, 32'hFFFF_FFF9, 32'd2),         64'hFFFFFFFF_FFFFFFFD);
    pin("s7_-2",     model(1'b1, 32'd7, 32'hFFFF_FFFE),         64'h00000001_FFFFFFFD);
    pin("smin_-1",   model(1'b1, 32'h8000_0000, 32'hFFFF_FFFF), 64'h00000000_80000000);
    pin("umax_1",    model(1'b0, 32'hFFFF_FFFF, 32'd1),         64'h00000000_FFFFFFFF);
    pin("u5_9",      model(1'b0, 32'd5, 32'd9),                 64'h00000005_00000000);
    pin("u9_3",      model(1'b0, 32'd9, 32'd3),                 64'h00000000_00000003);
    pin("div0",      model(1'b0, 32'h1234_5678, 32'd0),         64'd0);

    cyc(1'b0, 64'd0);
    cyc(1'b0, 64'd0);
    rst = 1'b1;
    cyc(1'b0, 64'd0);

    // Directed cases.
    op("u100_7",  1'b0, 32'd100, 32'd7, 3, 0);
    op("s-7_2",   1'b1, 32'hFFFF_FFF9, 32'd2, 1, 0);
    op("s7_-2",   1'b1, 32'd7, 32'hFFFF_FFFE, 1, 0);
    op("div0",    1'b0, 32'h1234_5678, 32'd0, 4, 0);
    op("umax_1",  1'b0, 32'hFFFF_FFFF, 32'd1, 0, 0);
    op("smin_-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0);
    op("u5_9",    1'b0, 32'd5, 32'd9, 1, 0);
    op("pulse",   1'b1, 32'hDEAD_BEEF, 32'd13, 0, 3);

    // Start together with annul in the idle state is not accepted.
    tag = "annul_idle";
    start = 1'b1; annul = 1'b1; op1 = 32'd50; op2 = 32'd5;
    cyc(1'b0, 64'd0);
    cyc(1'b0, 64'd0);
    annul = 1'b0; start = 1'b0;
    cyc(1'b0, 64'd0);

    op_annul(32'd100, 32'd7, 10);
    op("after_annul", 1'b0, 32'd9, 32'd3, 1, 0);
    op_annul(32'd100, 32'd7, 33);
    op("after_annul33", 1'b1, 32'hFFFF_FF00, 32'd7, 0, 0);
    op_reset(32'd100, 32'd7, 20);
    op("after_reset", 1'b0, 32'd100, 32'd7, 1, 0);

    // Randomized operations with random holds, short pulses, aborts and idle gaps.
    for (int n = 0; n < 60; n++) begin
      int kind;
      kind = $urandom % 10;
      if (kind == 0) op_annul($urandom, $urandom | 32'd1, $urandom_range(1, 33));
      else if (kind == 1) op_reset($urandom, $urandom, $urandom_range(1, 33));
      op("rand", 1'($urandom), pick(), pick(), $urandom % 3,
         ($urandom % 4 == 0) ? $urandom_range(1, 32) : 0);
      for (int g = 0; g < int'($urandom % 3); g++) cyc(1'b0, 64'd0);
    end

    cyc(1'b0, 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Safety net against a stuck run.
  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t got no completion want completion", $time);
    $fatal(1, "timeout");
  end

endmodule
